// File: rtl/lod_job_scheduler.sv
// lod_job_scheduler: serves a latched request mask from its highest set bit to
// its lowest, one shared-ALU operation at a time.
module lod_job_scheduler #(
    parameter int unsigned NREQ = 32,
    // Bits needed to hold any index 0..NREQ-1.
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            aclr,
    input  logic            ce,
    input  logic            sclr,
    input  logic            start,
    input  logic [NREQ-1:0] req_vec,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    input  logic            grant_ready,
    input  logic            alu_done,
    output logic            busy,
    output logic            done,
    output logic [IDXW:0]   served_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StIssue,
        StWait,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] lod_idx;
    logic [IDXW:0]   cnt_q, cnt_d;

    // Leading-one detect: ascending scan, so the highest set bit is the last to win.
    always_comb begin
        lod_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pend_q[i]) begin
                lod_idx = IDXW'(i);
            end
        end
    end

    // State and datapath registers; sclr outranks ce, ce=0 freezes everything.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= StIdle;
            pend_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (sclr) begin
            state_q <= StIdle;
            pend_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d = '0;
                    if (|req_vec) begin
                        pend_d  = req_vec;
                        state_d = StSelect;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StSelect: begin
                idx_d   = lod_idx;
                state_d = StIssue;
            end
            StIssue: begin
                // A coincident alu_done is not looked at here, so it is dropped.
                if (grant_ready) begin
                    pend_d[idx_q] = 1'b0;
                    cnt_d         = cnt_q + {{IDXW{1'b0}}, 1'b1};
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (alu_done) begin
                    state_d = (|pend_q) ? StSelect : StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        grant_valid = (state_q == StIssue);
        busy        = (state_q == StSelect) || (state_q == StIssue) || (state_q == StWait);
        done        = (state_q == StFinish);
    end

    assign grant_idx  = idx_q;
    assign served_cnt = cnt_q;

endmodule

// File: tb/tb_lod_job_scheduler.sv
// Directed self-checking bench for lod_job_scheduler (NREQ=32).
module tb_lod_job_scheduler;

    logic        clk;
    logic        aclr;
    logic        ce;
    logic        sclr;
    logic        start;
    logic [31:0] req_vec;
    logic        grant_valid;
    logic [4:0]  grant_idx;
    logic        grant_ready;
    logic        alu_done;
    logic        busy;
    logic        done;
    logic [5:0]  served_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Results recorded by run_batch.
    logic [4:0] got_idx [0:63];
    int         got_n;
    int         done_pulses;
    int         first_gv;
    int         gv_cycles;
    bit         idx_unstable;
    bit         gap_bad;
    bit         timeout;
    bit         busy_at_done;
    int         extra_gv;

    lod_job_scheduler #(.NREQ(32)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .ce          (ce),
        .sclr        (sclr),
        .start       (start),
        .req_vec     (req_vec),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_ready (grant_ready),
        .alu_done    (alu_done),
        .busy        (busy),
        .done        (done),
        .served_cnt  (served_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one batch acting as the ALU and records what the DUT did.
    task automatic run_batch(input logic [31:0] req, input int ready_wait,
                             input int done_lat, input bit disturb);
        int         cycle;
        int         stall;
        int         cd;
        int         last_done;
        bit         prev_gv;
        logic [4:0] prev_idx;
        got_n        = 0;
        done_pulses  = 0;
        first_gv     = -1;
        gv_cycles    = 0;
        idx_unstable = 0;
        gap_bad      = 0;
        timeout      = 0;
        busy_at_done = 1;
        extra_gv     = 0;
        start        = 1'b1;
        req_vec      = req;
        grant_ready  = 1'b0;
        alu_done     = 1'b0;
        step();
        start     = 1'b0;
        cycle     = 1;
        stall     = 0;
        cd        = 0;
        last_done = -1;
        prev_gv   = 0;
        prev_idx  = '0;
        while (1) begin
            if (done) begin
                done_pulses++;
                busy_at_done = busy;
                start        = 1'b0;
                break;
            end
            if (cycle > 1000) begin
                timeout = 1;
                break;
            end
            if (disturb) begin
                start   = 1'b1;
                req_vec = ~req;
            end
            if (grant_valid) begin
                gv_cycles++;
                if (first_gv < 0) first_gv = cycle;
                if (prev_gv && (grant_idx !== prev_idx)) idx_unstable = 1;
                if (!prev_gv && last_done >= 0) begin
                    if (cycle - last_done != 2) gap_bad = 1;
                    last_done = -1;
                end
                prev_idx = grant_idx;
                alu_done = disturb;
                if (stall < ready_wait) begin
                    grant_ready = 1'b0;
                    stall++;
                    prev_gv = 1;
                end else begin
                    grant_ready    = 1'b1;
                    got_idx[got_n] = grant_idx;
                    got_n++;
                    stall   = 0;
                    cd      = done_lat;
                    prev_gv = 0;
                end
            end else begin
                grant_ready = 1'b0;
                alu_done    = 1'b0;
                prev_gv     = 0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        alu_done  = 1'b1;
                        last_done = cycle;
                    end
                end
            end
            cycle++;
            step();
        end
        start       = 1'b0;
        req_vec     = '0;
        grant_ready = 1'b0;
        alu_done    = 1'b0;
        repeat (4) begin
            step();
            if (done) done_pulses++;
            if (grant_valid) extra_gv++;
        end
    endtask

    task automatic test_reset();
        aclr = 1'b1; ce = 1'b1; sclr = 1'b0; start = 1'b0; req_vec = '0;
        grant_ready = 1'b0; alu_done = 1'b0;
        #2;
        n_checks++;
        if ({grant_valid, grant_idx, busy, done, served_cnt} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gv=%0b idx=%0d busy=%0b done=%0b cnt=%0d, want all 0",
                     grant_valid, grant_idx, busy, done, served_cnt);
        end
        step();
        aclr = 1'b0;
        // Get into ISSUE with one grant already served: req bits 4 and 3.
        start = 1'b1; req_vec = 32'h18;
        step();
        start = 1'b0;
        step();
        grant_ready = 1'b1;
        step();
        grant_ready = 1'b0; alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        step();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 5'd3 || served_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL pre_reset_issue: got gv=%0b idx=%0d cnt=%0d, want gv=1 idx=3 cnt=1",
                     grant_valid, grant_idx, served_cnt);
        end
        aclr = 1'b1;
        #1;
        n_checks++;
        if ({grant_valid, grant_idx, busy, done, served_cnt} !== 14'd0) begin
            n_fail++;
            $display("FAIL async_reset_mid_issue: got gv=%0b idx=%0d busy=%0b done=%0b cnt=%0d, want all 0",
                     grant_valid, grant_idx, busy, done, served_cnt);
        end
        #2;
        aclr = 1'b0;
        step();
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abandoned_batch_quiet: got done=%0b busy=%0b gv=%0b, want 0 0 0",
                     done, busy, grant_valid);
        end
        // Synchronous clear with ce=0 still clears.
        start = 1'b1; req_vec = 32'h4;
        step();
        start = 1'b0;
        step();
        sclr = 1'b1; ce = 1'b0;
        step();
        sclr = 1'b0; ce = 1'b1;
        n_checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b0 || grant_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL sclr_over_ce: got gv=%0b busy=%0b idx=%0d, want 0 0 0",
                     grant_valid, busy, grant_idx);
        end
        // Empty batch.
        start = 1'b1; req_vec = '0;
        step();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || served_cnt !== 6'd0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_done: got done=%0b busy=%0b cnt=%0d gv=%0b, want 1 0 0 0",
                     done, busy, served_cnt, grant_valid);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_done_width: got done=%0b gv=%0b, want 0 0", done, grant_valid);
        end
    endtask

    task automatic test_basic_order();
        logic [31:0] req;
        logic [4:0]  exp_idx [0:63];
        int          exp_n;
        req   = 32'h8000_0005;
        exp_n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                exp_idx[exp_n] = 5'(i);
                exp_n++;
            end
        end
        run_batch(req, 0, 3, 0);
        n_checks++;
        if (timeout) begin
            n_fail++;
            $display("FAIL basic_timeout: batch did not finish within budget");
        end
        n_checks++;
        if (got_n != exp_n) begin
            n_fail++;
            $display("FAIL basic_grant_count: got %0d want %0d", got_n, exp_n);
        end
        for (int k = 0; k < exp_n && k < got_n; k++) begin
            n_checks++;
            if (got_idx[k] !== exp_idx[k]) begin
                n_fail++;
                $display("FAIL basic_order[%0d]: got %0d want %0d", k, got_idx[k], exp_idx[k]);
            end
        end
        n_checks++;
        if (first_gv != 2) begin
            n_fail++;
            $display("FAIL basic_start_latency: got %0d want 2", first_gv);
        end
        n_checks++;
        if (gap_bad) begin
            n_fail++;
            $display("FAIL basic_done_to_grant: got gap!=2 want 2");
        end
        n_checks++;
        if (done_pulses != 1 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got pulses=%0d busy_at_done=%0b want 1 0",
                     done_pulses, busy_at_done);
        end
        n_checks++;
        if (served_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL basic_served_hold: got %0d want 3", served_cnt);
        end
    endtask

    task automatic test_backpressure();
        run_batch(32'h0000_0010, 5, 3, 0);
        n_checks++;
        if (timeout || got_n != 1 || got_idx[0] !== 5'd4) begin
            n_fail++;
            $display("FAIL bp_grant: got timeout=%0b n=%0d idx=%0d want 0 1 4",
                     timeout, got_n, got_idx[0]);
        end
        n_checks++;
        if (gv_cycles != 6 || idx_unstable) begin
            n_fail++;
            $display("FAIL bp_valid_hold: got cycles=%0d unstable=%0b want 6 0",
                     gv_cycles, idx_unstable);
        end
        n_checks++;
        if (served_cnt !== 6'd1 || done_pulses != 1 || extra_gv != 0) begin
            n_fail++;
            $display("FAIL bp_served: got cnt=%0d pulses=%0d extra_gv=%0d want 1 1 0",
                     served_cnt, done_pulses, extra_gv);
        end
    endtask

    task automatic test_ce_stall();
        start = 1'b1; req_vec = 32'h2;
        step();
        start = 1'b0;
        step();
        // Stall in ISSUE: grant_valid held, grant_ready ignored.
        ce = 1'b0; grant_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 5'd1 || served_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL ce_hold_issue: got gv=%0b idx=%0d cnt=%0d want 1 1 0",
                     grant_valid, grant_idx, served_cnt);
        end
        ce = 1'b1;
        step();
        grant_ready = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || served_cnt !== 6'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_handshake: got gv=%0b cnt=%0d busy=%0b want 0 1 1",
                     grant_valid, served_cnt, busy);
        end
        // Stall in WAIT with an alu_done pulse that must be lost.
        ce = 1'b0;
        step();
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        step();
        step();
        ce = 1'b1;
        step();
        step();
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_stall_done_ignored: got busy=%0b done=%0b gv=%0b want 1 0 0",
                     busy, done, grant_valid);
        end
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || served_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL ce_finish: got done=%0b busy=%0b cnt=%0d want 1 0 1",
                     done, busy, served_cnt);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_done_width: got %0b want 0", done);
        end
    endtask

    task automatic test_ignored_events();
        logic [31:0] req;
        logic [4:0]  exp_idx [0:63];
        int          exp_n;
        req   = 32'h0000_0A41;
        exp_n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                exp_idx[exp_n] = 5'(i);
                exp_n++;
            end
        end
        run_batch(req, 1, 2, 1);
        n_checks++;
        if (timeout || got_n != exp_n) begin
            n_fail++;
            $display("FAIL ign_grant_count: got timeout=%0b n=%0d want 0 %0d",
                     timeout, got_n, exp_n);
        end
        for (int k = 0; k < exp_n && k < got_n; k++) begin
            n_checks++;
            if (got_idx[k] !== exp_idx[k]) begin
                n_fail++;
                $display("FAIL ign_order[%0d]: got %0d want %0d", k, got_idx[k], exp_idx[k]);
            end
        end
        n_checks++;
        if (served_cnt !== 6'(exp_n) || done_pulses != 1 || extra_gv != 0) begin
            n_fail++;
            $display("FAIL ign_served: got cnt=%0d pulses=%0d extra_gv=%0d want %0d 1 0",
                     served_cnt, done_pulses, extra_gv, exp_n);
        end
    endtask

    task automatic test_full_mask();
        run_batch(32'hFFFF_FFFF, 0, 3, 0);
        n_checks++;
        if (timeout || got_n != 32) begin
            n_fail++;
            $display("FAIL full_grant_count: got timeout=%0b n=%0d want 0 32", timeout, got_n);
        end
        for (int k = 0; k < 32 && k < got_n; k++) begin
            n_checks++;
            if (got_idx[k] !== 5'(31 - k)) begin
                n_fail++;
                $display("FAIL full_order[%0d]: got %0d want %0d", k, got_idx[k], 31 - k);
            end
        end
        n_checks++;
        if (served_cnt !== 6'd32 || done_pulses != 1 || gap_bad) begin
            n_fail++;
            $display("FAIL full_served: got cnt=%0d pulses=%0d gap_bad=%0b want 32 1 0",
                     served_cnt, done_pulses, gap_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_backpressure();
        test_ce_stall();
        test_ignored_events();
        test_full_mask();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
